// File: rtl/fir_serial_mac.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fir_serial_mac
//  Purpose  : Time-multiplexed FIR filter. One sample is accepted per
//             valid/ready handshake into an enable-gated delay line. The tap
//             sum is then accumulated over NTAPS cycles on a single
//             multiplier. The scaled result is presented on a valid/ready
//             output port.
//  Ports    : clk_i, rst_n_i (async, active-low)
//             s_valid_i / s_ready_o / s_data_i  - sample input handshake
//             coeff_i                           - tap k at [k*CW +: CW]
//             m_valid_o / m_ready_i / m_data_o  - result output handshake
//             busy_o                            - MAC or OUT in progress
//  Options  : FIR_SAT_EN - when defined, the scaled result is clamped to the
//             OW-bit signed range. When undefined, the low OW bits are kept
//             (wraparound).
//  Revision : 1.0 - initial release
// ============================================================================
module fir_serial_mac #(
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int NTAPS = 8,
    parameter int OW    = 16,
    parameter int SHIFT = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [DW-1:0]         s_data_i,
    input  logic [NTAPS*CW-1:0]   coeff_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [OW-1:0]         m_data_o,
    output logic                  busy_o
);

    localparam int IW = $clog2(NTAPS);
    localparam int PW = DW + CW;
    localparam int AW = DW + CW + IW;
    localparam logic [IW-1:0] c_LAST_IDX = IW'(NTAPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic signed [DW-1:0]  r_x [NTAPS];
    logic signed [CW-1:0]  w_c [NTAPS];
    logic signed [AW-1:0]  r_acc;
    logic signed [AW-1:0]  w_acc_next;
    logic signed [AW-1:0]  w_y;
    logic signed [PW-1:0]  w_prod;
    logic [IW-1:0]         r_idx;
    logic [OW-1:0]         r_m_data;
    logic [OW-1:0]         w_m_data_next;
    logic                  w_accept;
    logic                  w_last;

    // Unpack the flat coefficient bus so taps can be selected by index.
    generate
        for (genvar k = 0; k < NTAPS; k++) begin : g_coeff
            assign w_c[k] = coeff_i[k*CW +: CW];
        end
    endgenerate

    // Single shared multiplier; the product is sign-extended into the
    // accumulator, which has log2(NTAPS) guard bits so it cannot overflow.
    assign w_prod     = r_x[r_idx] * w_c[r_idx];
    assign w_acc_next = r_acc + {{(AW-PW){w_prod[PW-1]}}, w_prod};
    assign w_y        = w_acc_next >>> SHIFT;

`ifdef FIR_SAT_EN
    localparam logic signed [AW-1:0] c_Y_MAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW-1:0] c_Y_MIN = ~c_Y_MAX;

    always_comb begin
        w_m_data_next = w_y[OW-1:0];
        if (w_y > c_Y_MAX) begin
            w_m_data_next = c_Y_MAX[OW-1:0];
        end else if (w_y < c_Y_MIN) begin
            w_m_data_next = c_Y_MIN[OW-1:0];
        end
    end
`else
    assign w_m_data_next = w_y[OW-1:0];
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        s_ready_o    = 1'b0;
        busy_o       = 1'b0;
        m_valid_o    = 1'b0;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                s_ready_o = 1'b1;
                if (s_valid_i) begin
                    w_accept     = 1'b1;
                    w_state_next = S_MAC;
                end
            end
            S_MAC: begin
                busy_o = 1'b1;
                if (r_idx == c_LAST_IDX) begin
                    w_last       = 1'b1;
                    w_state_next = S_OUT;
                end
            end
            S_OUT: begin
                busy_o    = 1'b1;
                m_valid_o = 1'b1;
                if (m_ready_i) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: delay line, accumulator, tap index, output register.
    // The delay line only moves on an accepted sample, so filter history
    // survives output backpressure.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < NTAPS; k++) begin
                r_x[k] <= '0;
            end
            r_acc    <= '0;
            r_idx    <= '0;
            r_m_data <= '0;
        end else begin
            if (w_accept) begin
                r_x[0] <= $signed(s_data_i);
                for (int k = 1; k < NTAPS; k++) begin
                    r_x[k] <= r_x[k-1];
                end
                r_acc <= '0;
                r_idx <= '0;
            end else if (r_state == S_MAC) begin
                r_acc <= w_acc_next;
                r_idx <= r_idx + IW'(1);
                // The final sum is taken from the adder output so the result
                // is ready the same cycle the last tap is processed.
                if (w_last) begin
                    r_m_data <= w_m_data_next;
                end
            end
        end
    end

    assign m_data_o = r_m_data;

endmodule
`default_nettype wire

// File: doc/fir_serial_mac.md
# fir_serial_mac

Time-multiplexed FIR filter core: accepts one input sample per valid/ready handshake, holds it in an internal enable-gated sample delay line, and computes the tap sum over `NTAPS` clock cycles on a single multiplier. It consumes the delayed samples that the width-parameterised delay flops produce. It presents one scaled result per input sample on a valid/ready output port to the downstream datapath.

## Interface
- `DW`, 16: input sample width, signed two's complement.
- `CW`, 16: coefficient width, signed.
- `NTAPS`, 8: number of taps, ≥2.
- `OW`, 16: output width, signed.
- `SHIFT`, 15: arithmetic right shift applied to the accumulator before output.
- `clk_i`  in  1  clock; all state changes on rising edge.
- `rst_n_i`  in  1  asynchronous, active-low reset.
- `s_valid_i`  in  1  input sample valid.
- `s_ready_o`  out  1  core can accept a sample; high iff state is IDLE.
- `s_data_i`  in  DW  input sample.
- `coeff_i`  in  NTAPS*CW  coefficients; tap k occupies bits [k*CW +: CW]; tap 0 weights the newest sample.
- `m_valid_o`  out  1  output result valid.
- `m_ready_i`  in  1  downstream accepts result.
- `m_data_o`  out  OW  filtered output.
- `busy_o`  out  1  high in MAC or OUT state.

## Operation
- Accumulator width `AW = DW + CW + $clog2(NTAPS)`; all products and sums are signed, sign-extended to `AW`; no overflow is possible in the accumulator.
- Delay line `x[0..NTAPS-1]`, each `DW` wide, shifts only on input handshake: `x[0] <= s_data_i`, `x[k] <= x[k-1]`.
- FSM states:
  - IDLE: `s_ready_o=1`. On `s_valid_i` the delay line shifts, the accumulator clears, tap index clears to 0, and the state goes to MAC.
  - MAC: each cycle `acc += x[idx]*c[idx]` and `idx++`. On the cycle with `idx==NTAPS-1`, `m_data_o` loads from the final sum (`acc_next`), `m_valid_o` is set, and the state goes to OUT.
  - OUT: `m_valid_o=1`. `m_data_o` is held until `m_valid_o && m_ready_i`; then `m_valid_o` clears and the state goes to IDLE.
- Output scaling: `y = acc_final >>> SHIFT` (arithmetic shift, floor rounding). Without saturation, `m_data_o = y[OW-1:0]` (wrap).
- `coeff_i` is sampled during MAC. It must be held stable while `busy_o=1`; changes while `busy_o=0` take effect on the next sample.
- `s_valid_i` and `s_data_i` are ignored outside IDLE, and the delay line does not shift.
- The delay line is never cleared except by reset: filter history persists across backpressure stalls.

## Timing
- Reset values: state IDLE, `x[*]=0`, `acc=0`, `idx=0`, `m_data_o=0`, `m_valid_o=0`, `busy_o=0`, `s_ready_o=1` (combinational from state). Inputs are ignored while `rst_n_i=0`.
- Latency: input handshake at edge E0 puts MAC at E1..E_NTAPS. `m_valid_o` rises after E_NTAPS, exactly `NTAPS` cycles after acceptance.
- Throughput: with `m_ready_i` tied high, one sample per `NTAPS+2` cycles (accept, NTAPS MAC cycles, one OUT cycle).
- Backpressure: in OUT with `m_ready_i=0`, `m_valid_o` and `m_data_o` stay stable indefinitely, and `s_ready_o` stays 0.
- Reset asserted mid-MAC or mid-OUT: all state returns to reset values immediately (asynchronous). The in-flight result is discarded and no partial output is presented.

## Configuration
- `FIR_SAT_EN` defined: `y` is clamped to `[-2^(OW-1), 2^(OW-1)-1]` before driving `m_data_o`.
- `FIR_SAT_EN` undefined: `m_data_o` takes the low `OW` bits of `y` (wraparound), and no compare logic is built.

## Test plan
Common setup: `NTAPS=4`, `DW=CW=OW=16`, `SHIFT=0`, coefficients {1,2,3,4}, `m_ready_i=1` unless stated.

- Impulse: samples 1,0,0,0,0 → `m_data_o` sequence 1,2,3,4,0.
- Step: samples 1,1,1,1,1 → 1,3,6,10,10.
- Latency/throughput: `s_valid_i` held high → `m_valid_o` rises exactly 4 cycles after each accept edge, and `s_ready_o` is high 1 cycle in every 6.
- Backpressure: `m_ready_i=0` for 5 cycles during OUT while driving `s_valid_i=1` with value 7 → `m_data_o` is unchanged, `s_ready_o=0`, and sample 7 is never absorbed (next impulse response is unaffected).
- Saturation: all taps 32767, samples 32767 ×4 → with `FIR_SAT_EN` the 4th output is 32767; without it the 4th output is `(4*0x3FFF0001)[15:0]` = 4. Also check all samples −32768 with all taps 32767: with `FIR_SAT_EN` the result is −32768.
- Reset mid-MAC: pulse `rst_n_i` low at the 2nd MAC cycle → `m_valid_o=0` and `s_ready_o=1` immediately. A following impulse then yields 1,2,3,4, which proves the delay line was cleared.
